// File: rtl/x_mem_seq.sv
// Execute-stage load/store sequencer: splits double ops into two word beats over a req/gnt/rvalid port.
// Request is combinational in the accept cycle (zero-wait grant); held stable until gnt; stalls decode/PC until the last beat completes.
module x_mem_seq #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            x_valid_i,
    input  logic [2:0]      x_op_i,
    input  logic [AW-1:0]   x_addr_i,
    input  logic [2*DW-1:0] x_wdata_i,
    input  logic [4:0]      x_rd_i,
    output logic            mem_req_o,
    output logic            mem_we_o,
    output logic [AW-1:0]   mem_addr_o,
    output logic [DW-1:0]   mem_wdata_o,
    input  logic            mem_gnt_i,
    input  logic            mem_rvalid_i,
    input  logic [DW-1:0]   mem_rdata_i,
    output logic            x_stall_d_o,
    output logic            d_stall_pc_o,
    output logic            wb_valid_o,
    output logic [4:0]      wb_rd_o,
    output logic [2*DW-1:0] wb_data_o,
    output logic            err_o
);
    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t            state;
    logic [AW-1:0]     base_q;
    logic [2*DW-1:0]   wdata_q;
    logic [4:0]        rd_q;
    logic              store_q;
    logic              dbl_q;
    logic              beat_q;
    logic [DW-1:0]     lo_q;

    logic              op_legal;
    logic              x_store;
    logic              accept;
    logic              start;
    logic              idle;
    logic [AW-1:0]     cur_base;
    logic [2*DW-1:0]   cur_wdata;
    logic              cur_store;
    logic              cur_dbl;
    logic              cur_beat;
    logic              req_phase;
    logic              last_beat;
    logic              done_last;

    always_comb begin
        op_legal = 1'b0;
        case (x_op_i)
            3'b001, 3'b010, 3'b101, 3'b110: op_legal = 1'b1;
            default:                        op_legal = 1'b0;
        endcase
        x_store   = (x_op_i == 3'b010) || (x_op_i == 3'b110);
        idle      = (state == IDLE);
        accept    = idle && x_valid_i && op_legal;
        start     = accept && (x_addr_i[1:0] == 2'b00);

        // In the accept cycle the beat is driven straight from execute's inputs.
        cur_base  = idle ? x_addr_i  : base_q;
        cur_wdata = idle ? x_wdata_i : wdata_q;
        cur_store = idle ? x_store   : store_q;
        cur_dbl   = idle ? x_op_i[2] : dbl_q;
        cur_beat  = idle ? 1'b0      : beat_q;

        req_phase = start || (state == REQ);
        last_beat = (cur_beat == cur_dbl);
        done_last = (req_phase && mem_gnt_i && cur_store && last_beat)
                 || ((state == RESP) && mem_rvalid_i && last_beat);

        mem_req_o    = req_phase;
        mem_we_o     = req_phase && cur_store;
        mem_addr_o   = cur_base + (cur_beat ? AW'(DW/8) : AW'(0));
        mem_wdata_o  = cur_beat ? cur_wdata[2*DW-1:DW] : cur_wdata[DW-1:0];
        x_stall_d_o  = (start || !idle) && !done_last;
        // A single load waiting for data need not hold the PC.
        d_stall_pc_o = x_stall_d_o && !((state == RESP) && !dbl_q);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            base_q     <= '0;
            wdata_q    <= '0;
            rd_q       <= '0;
            store_q    <= 1'b0;
            dbl_q      <= 1'b0;
            beat_q     <= 1'b0;
            lo_q       <= '0;
            wb_valid_o <= 1'b0;
            wb_rd_o    <= '0;
            wb_data_o  <= '0;
            err_o      <= 1'b0;
        end else begin
            wb_valid_o <= 1'b0;
            err_o      <= 1'b0;
            if (accept && !start) begin
                err_o <= 1'b1;
            end
            if (start) begin
                base_q  <= x_addr_i;
                wdata_q <= x_wdata_i;
                rd_q    <= x_rd_i;
                store_q <= x_store;
                dbl_q   <= x_op_i[2];
                beat_q  <= 1'b0;
                state   <= REQ;
            end
            if (req_phase && mem_gnt_i) begin
                if (!cur_store) begin
                    state <= RESP;
                end else if (last_beat) begin
                    state <= IDLE;
                end else begin
                    beat_q <= 1'b1;
                    state  <= REQ;
                end
            end
            if ((state == RESP) && mem_rvalid_i) begin
                if (last_beat) begin
                    wb_valid_o <= 1'b1;
                    wb_rd_o    <= rd_q;
                    wb_data_o  <= beat_q ? {mem_rdata_i, lo_q} : {{DW{1'b0}}, mem_rdata_i};
                    state      <= IDLE;
                end else begin
                    lo_q   <= mem_rdata_i;
                    beat_q <= 1'b1;
                    state  <= REQ;
                end
            end
        end
    end
endmodule

// File: tb/tb_x_mem_seq.sv
// Scoreboarded bench for x_mem_seq: granted requests and writeback pulses are matched against queued expectations.
module tb_x_mem_seq;
    localparam int AW = 32;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            x_valid;
    logic [2:0]      x_op;
    logic [AW-1:0]   x_addr;
    logic [2*DW-1:0] x_wdata;
    logic [4:0]      x_rd;
    logic            mem_req;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic            mem_gnt;
    logic            mem_rvalid;
    logic [DW-1:0]   mem_rdata;
    logic            x_stall_d;
    logic            d_stall_pc;
    logic            wb_valid;
    logic [4:0]      wb_rd;
    logic [2*DW-1:0] wb_data;
    logic            err;

    int checks = 0;
    int failures = 0;

    logic [AW+DW:0]   exp_req[$];
    logic [4+2*DW:0]  exp_wb[$];
    logic [AW+DW:0]   er;
    logic [4+2*DW:0]  ew;

    x_mem_seq #(.AW(AW), .DW(DW)) dut (
        .clk_i(clk), .rst_i(rst),
        .x_valid_i(x_valid), .x_op_i(x_op), .x_addr_i(x_addr), .x_wdata_i(x_wdata), .x_rd_i(x_rd),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
        .x_stall_d_o(x_stall_d), .d_stall_pc_o(d_stall_pc),
        .wb_valid_o(wb_valid), .wb_rd_o(wb_rd), .wb_data_o(wb_data), .err_o(err)
    );

    always #5 clk = ~clk;

    // Scoreboard: every accepted request and every writeback pulse must match the next expectation.
    always @(negedge clk) begin
        if (!rst && mem_req && mem_gnt) begin
            checks++;
            if (exp_req.size() == 0) begin
                failures++;
                $display("FAIL req_unexpected we=%0b addr=%h wdata=%h", mem_we, mem_addr, mem_wdata);
            end else begin
                er = exp_req.pop_front();
                if (mem_we !== er[AW+DW] || mem_addr !== er[AW+DW-1:DW] ||
                    (er[AW+DW] && mem_wdata !== er[DW-1:0])) begin
                    failures++;
                    $display("FAIL req_match got we=%0b addr=%h wdata=%h want we=%0b addr=%h wdata=%h",
                             mem_we, mem_addr, mem_wdata, er[AW+DW], er[AW+DW-1:DW], er[DW-1:0]);
                end
            end
        end
        if (!rst && wb_valid) begin
            checks++;
            if (exp_wb.size() == 0) begin
                failures++;
                $display("FAIL wb_unexpected rd=%0d data=%h", wb_rd, wb_data);
            end else begin
                ew = exp_wb.pop_front();
                if (wb_rd !== ew[4+2*DW:2*DW] || wb_data !== ew[2*DW-1:0]) begin
                    failures++;
                    $display("FAIL wb_match got rd=%0d data=%h want rd=%0d data=%h",
                             wb_rd, wb_data, ew[4+2*DW:2*DW], ew[2*DW-1:0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        x_valid    = 1'b0;
        x_op       = 3'b000;
        x_addr     = 32'hDEAD_0001;
        x_wdata    = 64'hBAD0_BAD0_BAD0_BAD0;
        x_rd       = 5'd31;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'hFFFF_FFFF;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({mem_req, x_stall_d, d_stall_pc, wb_valid, err} !== 5'b0) begin
            failures++;
            $display("FAIL reset_ctrl got req/stall/pc/wb/err=%b want 00000",
                     {mem_req, x_stall_d, d_stall_pc, wb_valid, err});
        end
        checks++;
        if (wb_data !== '0 || wb_rd !== '0) begin
            failures++;
            $display("FAIL reset_wb got data=%h rd=%0d want 0", wb_data, wb_rd);
        end
    endtask

    task automatic test_sw();
        next_cycle();
        x_valid = 1'b1; x_op = 3'b010; x_addr = 32'h100; x_wdata = 64'hA5; mem_gnt = 1'b1;
        exp_req.push_back({1'b1, 32'h100, 32'hA5});
        @(negedge clk);
        checks++;
        if (x_stall_d !== 1'b0 || d_stall_pc !== 1'b0) begin
            failures++;
            $display("FAIL sw_nostall got stall=%b pc=%b want 0 0", x_stall_d, d_stall_pc);
        end
        next_cycle();
        idle_inputs();
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b0) begin
            failures++;
            $display("FAIL sw_single_req got req=%b want 0", mem_req);
        end
    endtask

    task automatic test_lw();
        int stall_cnt = 0;
        int pc_cnt = 0;
        exp_req.push_back({1'b0, 32'h40, 32'h0});
        exp_wb.push_back({5'd5, 64'h0000_0000_DEAD_BEEF});
        for (int c = 0; c < 5; c++) begin
            next_cycle();
            idle_inputs();
            if (c == 0) begin
                x_valid = 1'b1; x_op = 3'b001; x_addr = 32'h40; x_rd = 5'd5; mem_gnt = 1'b1;
            end
            if (c == 3) begin
                mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
            end
            @(negedge clk);
            if (c < 4) begin
                stall_cnt += int'(x_stall_d);
                pc_cnt    += int'(d_stall_pc);
            end
            if (c == 4) begin
                checks++;
                if (wb_valid !== 1'b1 || x_stall_d !== 1'b0) begin
                    failures++;
                    $display("FAIL lw_wb_pulse got wb_valid=%b stall=%b want 1 0", wb_valid, x_stall_d);
                end
            end
        end
        checks++;
        if (stall_cnt != 3 || pc_cnt != 1) begin
            failures++;
            $display("FAIL lw_stall_cycles got stall=%0d pc=%0d want 3 1", stall_cnt, pc_cnt);
        end
    endtask

    task automatic test_ld();
        int pc_diff = 0;
        int stall_bad = 0;
        exp_req.push_back({1'b0, 32'h200, 32'h0});
        exp_req.push_back({1'b0, 32'h204, 32'h0});
        exp_wb.push_back({5'd7, 32'h22, 32'h11});
        for (int c = 0; c < 9; c++) begin
            next_cycle();
            idle_inputs();
            if (c == 0) begin
                x_valid = 1'b1; x_op = 3'b101; x_addr = 32'h200; x_rd = 5'd7;
            end
            mem_gnt = (c == 2) || (c == 6);
            if (c == 3) begin mem_rvalid = 1'b1; mem_rdata = 32'h11; end
            if (c == 7) begin mem_rvalid = 1'b1; mem_rdata = 32'h22; end
            @(negedge clk);
            if (d_stall_pc !== x_stall_d) pc_diff++;
            if (x_stall_d !== (c < 7)) stall_bad++;
        end
        checks++;
        if (pc_diff != 0) begin
            failures++;
            $display("FAIL ld_pc_eq_stall got %0d differing cycles want 0", pc_diff);
        end
        checks++;
        if (stall_bad != 0) begin
            failures++;
            $display("FAIL ld_stall_window got %0d wrong cycles want 0", stall_bad);
        end
    endtask

    task automatic test_sd_wrap();
        int unstable = 0;
        int stall_bad = 0;
        int req_bad = 0;
        exp_req.push_back({1'b1, 32'hFFFF_FFFC, 32'h1111_AAAA});
        exp_req.push_back({1'b1, 32'h0000_0000, 32'h2222_BBBB});
        for (int c = 0; c < 6; c++) begin
            next_cycle();
            idle_inputs();
            if (c == 0) begin
                x_valid = 1'b1; x_op = 3'b110; x_addr = 32'hFFFF_FFFC;
                x_wdata = {32'h2222_BBBB, 32'h1111_AAAA};
            end
            mem_gnt = (c == 3) || (c == 4);
            @(negedge clk);
            if (c <= 3 && (mem_req !== 1'b1 || mem_addr !== 32'hFFFF_FFFC || mem_wdata !== 32'h1111_AAAA))
                unstable++;
            if (x_stall_d !== (c < 4)) stall_bad++;
            if (mem_req !== (c <= 4)) req_bad++;
        end
        checks++;
        if (unstable != 0) begin
            failures++;
            $display("FAIL sd_hold_stable got %0d unstable cycles want 0", unstable);
        end
        checks++;
        if (stall_bad != 0 || req_bad != 0) begin
            failures++;
            $display("FAIL sd_stall_req got stall_bad=%0d req_bad=%0d want 0 0", stall_bad, req_bad);
        end
    endtask

    task automatic test_misaligned();
        next_cycle();
        idle_inputs();
        x_valid = 1'b1; x_op = 3'b001; x_addr = 32'h102; mem_gnt = 1'b1;
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b0 || x_stall_d !== 1'b0 || d_stall_pc !== 1'b0) begin
            failures++;
            $display("FAIL mis_noaccess got req=%b stall=%b pc=%b want 0 0 0", mem_req, x_stall_d, d_stall_pc);
        end
        next_cycle();
        idle_inputs();
        @(negedge clk);
        checks++;
        if (err !== 1'b1 || mem_req !== 1'b0) begin
            failures++;
            $display("FAIL mis_err_pulse got err=%b req=%b want 1 0", err, mem_req);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL mis_err_one_cycle got err=%b want 0", err);
        end
    endtask

    task automatic test_reset_mid();
        exp_req.push_back({1'b0, 32'h300, 32'h0});
        next_cycle();
        idle_inputs();
        x_valid = 1'b1; x_op = 3'b101; x_addr = 32'h300; x_rd = 5'd9; mem_gnt = 1'b1;
        next_cycle();
        idle_inputs();
        next_cycle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'h55;
        @(negedge clk);
        checks++;
        if ({mem_req, x_stall_d, d_stall_pc, wb_valid, err} !== 5'b0) begin
            failures++;
            $display("FAIL rstmid_ctrl got req/stall/pc/wb/err=%b want 00000",
                     {mem_req, x_stall_d, d_stall_pc, wb_valid, err});
        end
        checks++;
        if (wb_data !== '0 || wb_rd !== '0) begin
            failures++;
            $display("FAIL rstmid_wb got data=%h rd=%0d want 0", wb_data, wb_rd);
        end
        next_cycle();
        idle_inputs();
        @(negedge clk);
        checks++;
        if (wb_valid !== 1'b0 || wb_data !== '0 || x_stall_d !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_rvalid_ignored got wb_valid=%b data=%h stall=%b want 0 0 0",
                     wb_valid, wb_data, x_stall_d);
        end
        exp_req.push_back({1'b1, 32'h8, 32'h77});
        next_cycle();
        x_valid = 1'b1; x_op = 3'b010; x_addr = 32'h8; x_wdata = 64'h77;
        @(negedge clk);
        checks++;
        if (x_stall_d !== 1'b1 || mem_req !== 1'b1) begin
            failures++;
            $display("FAIL post_rst_sw_wait got stall=%b req=%b want 1 1", x_stall_d, mem_req);
        end
        next_cycle();
        idle_inputs();
        mem_gnt = 1'b1;
        @(negedge clk);
        checks++;
        if (x_stall_d !== 1'b0 || mem_req !== 1'b1) begin
            failures++;
            $display("FAIL post_rst_sw_grant got stall=%b req=%b want 0 1", x_stall_d, mem_req);
        end
        next_cycle();
        idle_inputs();
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b0) begin
            failures++;
            $display("FAIL post_rst_sw_done got req=%b want 0", mem_req);
        end
    endtask

    initial begin
        test_reset();
        test_sw();
        test_lw();
        test_ld();
        test_sd_wrap();
        test_misaligned();
        test_reset_mid();
        next_cycle();
        @(negedge clk);
        checks++;
        if (exp_req.size() != 0 || exp_wb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got req_left=%0d wb_left=%0d want 0 0", exp_req.size(), exp_wb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
